array_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared single-port register-file memory (8 x 4-bit) used by the stage-1 memory display design.
- Requester 0 is the switch/key panel path; requester 1 is an auto-scan/playback unit.
- Grants one transaction at a time with round-robin priority and drives the memory's enable/rw/address/data inputs.
- Returns read data and a one-cycle acknowledge to the winning requester.

---
 rtl/array_mem_arbiter.sv | 103 ++++++++++
 tb/tb_array_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_mem_arbiter.sv
// Round-robin arbiter that sequences two requesters onto a single-port
// register-file memory and returns read data with a one-cycle acknowledge.
//
// state  | meaning
// IDLE   | waiting for a request; picks the winner and latches its fields
// ISSUE  | memory strobe cycle (mem_en high)
// RDWAIT | read data returns from memory; captured into the winner's rdata
// ACK    | winner's ack pulses; round-robin pointer moves to the other side
module array_mem_arbiter #(
  parameter int width     = 4,
  parameter int addr_bits = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic                 rw0,
  input  logic [addr_bits-1:0] addr0,
  input  logic [width-1:0]     wdata0,
  output logic                 ack0,
  output logic [width-1:0]     rdata0,
  input  logic                 req1,
  input  logic                 rw1,
  input  logic [addr_bits-1:0] addr1,
  input  logic [width-1:0]     wdata1,
  output logic                 ack1,
  output logic [width-1:0]     rdata1,
  output logic                 mem_en,
  output logic                 mem_rw,
  output logic [addr_bits-1:0] mem_addr,
  output logic [width-1:0]     mem_wdata,
  input  logic [width-1:0]     mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

  state_t state, state_next;
  logic   winner;
  logic   ptr;
  logic   grant;
  logic   grant_valid;

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_valid = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant       = ptr;
          grant_valid = 1'b1;
        end else if (req0) begin
          grant       = 1'b0;
          grant_valid = 1'b1;
        end else if (req1) begin
          grant       = 1'b1;
          grant_valid = 1'b1;
        end
        if (grant_valid) state_next = ISSUE;
      end
      ISSUE:   state_next = mem_rw ? RDWAIT : ACK;
      RDWAIT:  state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // mem_rw/mem_addr/mem_wdata double as the latched request fields.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      winner    <= 1'b0;
      ptr       <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != IDLE);
      mem_en <= (state_next == ISSUE);
      ack0   <= (state_next == ACK) && !winner;
      ack1   <= (state_next == ACK) && winner;
      if (state == IDLE && grant_valid) begin
        winner    <= grant;
        mem_rw    <= grant ? rw1 : rw0;
        mem_addr  <= grant ? addr1 : addr0;
        mem_wdata <= grant ? wdata1 : wdata0;
      end
      if (state == RDWAIT) begin
        if (winner) rdata1 <= mem_rdata;
        else        rdata0 <= mem_rdata;
      end
      if (state == ACK) ptr <= ~winner;
    end
  end

endmodule

// File: tb/tb_array_mem_arbiter.sv
// Directed/randomized bench for array_mem_arbiter with a memory model and a
// transaction-level reference model (memory image, rdata values, pointer).
module tb_array_mem_arbiter;
  localparam int W = 4;
  localparam int A = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [A-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] wdata0 = '0, wdata1 = '0;
  logic         ack0, ack1, mem_en, mem_rw, busy;
  logic [W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [A-1:0] mem_addr;

  logic         load_en = 1'b0;
  logic [A-1:0] load_addr = '0;
  logic [W-1:0] load_data = '0;
  logic [W-1:0] sim_mem [8];

  logic [W-1:0] ref_mem [8];
  logic [W-1:0] exp_rdata [2];
  logic         ref_ptr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  array_mem_arbiter #(.width(W), .addr_bits(A)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Single-port memory: writes on the strobe edge, read data one cycle later.
  always @(posedge clock) begin
    if (load_en) sim_mem[load_addr] <= load_data;
    else if (mem_en && !mem_rw) sim_mem[mem_addr] <= mem_wdata;
    if (mem_en && mem_rw) mem_rdata <= sim_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int who, input logic r, input logic rw,
                         input logic [A-1:0] a, input logic [W-1:0] d);
    if (who == 0) begin
      req0 = r; rw0 = rw; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; rw1 = rw; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mem_en"}, 32'(mem_en), 0);
    check({tag, "_mem_rw"}, 32'(mem_rw), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_acks"}, 32'({ack1, ack0}), 0);
    check({tag, "_rdata0"}, 32'(rdata0), 0);
    check({tag, "_rdata1"}, 32'(rdata1), 0);
  endtask

  // One transaction from a single requester; pulse drops req and scrambles
  // the fields right after the grant.
  task automatic txn(input int who, input logic rw, input logic [A-1:0] a,
                     input logic [W-1:0] d, input bit pulse);
    int lat = rw ? 3 : 2;
    set_req(who, 1'b1, rw, a, d);
    check("c0_busy", 32'(busy), 0);
    step();
    check("c1_mem_en", 32'(mem_en), 1);
    check("c1_mem_rw", 32'(mem_rw), 32'(rw));
    check("c1_mem_addr", 32'(mem_addr), 32'(a));
    if (!rw) check("c1_mem_wdata", 32'(mem_wdata), 32'(d));
    check("c1_busy", 32'(busy), 1);
    check("c1_acks", 32'({ack1, ack0}), 0);
    if (pulse) set_req(who, 1'b0, ~rw, a ^ 3'd7, ~d);
    for (int c = 2; c < lat; c++) begin
      step();
      check("wait_mem_en", 32'(mem_en), 0);
      check("wait_acks", 32'({ack1, ack0}), 0);
      check("wait_busy", 32'(busy), 1);
    end
    step();
    if (rw) exp_rdata[who] = ref_mem[a];
    else    ref_mem[a] = d;
    check("ack_ack0", 32'(ack0), (who == 0) ? 1 : 0);
    check("ack_ack1", 32'(ack1), (who == 1) ? 1 : 0);
    check("ack_rdata0", 32'(rdata0), 32'(exp_rdata[0]));
    check("ack_rdata1", 32'(rdata1), 32'(exp_rdata[1]));
    check("ack_mem_en", 32'(mem_en), 0);
    check("ack_busy", 32'(busy), 1);
    ref_ptr = (who == 0);
    set_req(who, 1'b0, rw, a, d);
    step();
    check("post_busy", 32'(busy), 0);
    check("post_acks", 32'({ack1, ack0}), 0);
  endtask

  // Both requesters write at once; only the pointer's choice completes.
  task automatic tie(input logic [A-1:0] a0, input logic [A-1:0] a1,
                     input logic [W-1:0] d0, input logic [W-1:0] d1);
    bit seen = 0;
    set_req(0, 1'b1, 1'b0, a0, d0);
    set_req(1, 1'b1, 1'b0, a1, d1);
    for (int c = 1; c <= 6 && !seen; c++) begin
      step();
      if (ack0 | ack1) begin
        seen = 1;
        check("tie_winner_ack1", 32'(ack1), 32'(ref_ptr));
        check("tie_latency", c, 2);
        if (ref_ptr) ref_mem[a1] = d1;
        else         ref_mem[a0] = d0;
        ref_ptr = ~ref_ptr;
        set_req(0, 1'b0, 1'b0, a0, d0);
        set_req(1, 1'b0, 1'b0, a1, d1);
      end
    end
    check("tie_ack_seen", 32'(seen), 1);
    step();
    check("tie_post_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [A-1:0] a0, a1;
    logic [W-1:0] d0, d1;
    logic         exp_who;
    int           last_ack, nacks;

    for (int i = 0; i < 2; i++) exp_rdata[i] = '0;
    ref_ptr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_addr = 3'(i);
      load_data = (i == 5) ? 4'h7 : 4'($urandom_range(0, 15));
      ref_mem[i] = load_data;
      step();
    end
    load_en = 1'b0;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_all_zero("after_reset");

    txn(0, 1'b0, 3'd3, 4'hA, 0);
    txn(1, 1'b1, 3'd5, 4'h0, 0);

    // Both held continuously: alternating grants, acks 3 cycles apart.
    a0 = 3'($urandom_range(0, 7));
    a1 = a0 ^ 3'd1;
    d0 = 4'($urandom_range(0, 15));
    d1 = 4'($urandom_range(0, 15));
    exp_who  = ref_ptr;
    last_ack = 0;
    nacks    = 0;
    set_req(0, 1'b1, 1'b0, a0, d0);
    set_req(1, 1'b1, 1'b0, a1, d1);
    for (int c = 1; c <= 14 && nacks < 4; c++) begin
      step();
      check("rr_both_acks", 32'(ack0 & ack1), 0);
      if (mem_en) check("rr_mem_addr", 32'(mem_addr), exp_who ? 32'(a1) : 32'(a0));
      if (ack0 | ack1) begin
        check("rr_order_ack1", 32'(ack1), 32'(exp_who));
        check("rr_spacing", c - last_ack, (nacks == 0) ? 2 : 3);
        if (exp_who) ref_mem[a1] = d1;
        else         ref_mem[a0] = d0;
        last_ack = c;
        nacks++;
        exp_who = ~exp_who;
        ref_ptr = exp_who;
        if (nacks == 4) begin
          set_req(0, 1'b0, 1'b0, a0, d0);
          set_req(1, 1'b0, 1'b0, a1, d1);
        end
      end
    end
    check("rr_ack_count", nacks, 4);
    step();
    check("rr_post_busy", 32'(busy), 0);

    txn(0, 1'b0, 3'd2, 4'hC, 0);
    txn(0, 1'b1, 3'd2, 4'h0, 0);
    txn(1, 1'b1, 3'd2, 4'h0, 0);

    for (int i = 0; i < 12; i++)
      txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 0);

    txn(0, 1'b1, 3'($urandom_range(0, 7)), 4'h0, 1);
    txn(0, 1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1);

    // Leave the pointer on requester 1, then reset during a requester 1 read.
    txn(0, 1'b0, 3'd6, 4'($urandom_range(0, 15)), 0);
    set_req(1, 1'b1, 1'b1, 3'd5, 4'h0);
    step();
    step();
    check("rst_pre_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    set_req(1, 1'b0, 1'b1, 3'd5, 4'h0);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    ref_ptr = 1'b0;
    step();
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_no_ack", 32'({ack1, ack0}), 0);
    end
    tie(3'd1, 3'd4, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    tie(3'd1, 3'd4, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    txn(1, 1'b1, 3'd4, 4'h0, 0);
    txn(0, 1'b1, 3'd1, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
